exec_muldiv: RTL and testbench

EXEC_MULDIV -- requirements
Module: exec_muldiv

---
 rtl/exec_muldiv_pkg.sv | 47 ++++
 rtl/exec_muldiv_div_iter.sv | 67 ++++++
 rtl/exec_muldiv.sv | 161 ++++++++++++++++
 tb/tb_exec_muldiv.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/exec_muldiv_pkg.sv
// Shared CPU definitions: operation codes, mul/div FSM states and op groupings.
package exec_muldiv_pkg;

  typedef enum logic [4:0] {
    OP_NOP   = 5'd0,
    OP_ADD   = 5'd1,
    OP_MULT  = 5'd2,
    OP_MULTU = 5'd3,
    OP_MUL   = 5'd4,
    OP_MADD  = 5'd5,
    OP_MADDU = 5'd6,
    OP_MSUB  = 5'd7,
    OP_MSUBU = 5'd8,
    OP_DIV   = 5'd9,
    OP_DIVU  = 5'd10,
    OP_MTHI  = 5'd11,
    OP_MTLO  = 5'd12,
    OP_MFHI  = 5'd13,
    OP_MFLO  = 5'd14
  } oper_t;

  typedef enum logic [2:0] {
    MD_IDLE = 3'd0,
    MD_MUL  = 3'd1,
    MD_DIV  = 3'd2,
    MD_FIX  = 3'd3,
    MD_DONE = 3'd4
  } muldiv_state_t;

  // One-hot op sets, indexed by the oper_t code.
  localparam logic [31:0] MUL_CLASS_OPS = (32'd1 << OP_MULT)  | (32'd1 << OP_MULTU) |
                                          (32'd1 << OP_MUL)   | (32'd1 << OP_MADD)  |
                                          (32'd1 << OP_MADDU) | (32'd1 << OP_MSUB)  |
                                          (32'd1 << OP_MSUBU);
  localparam logic [31:0] DIV_CLASS_OPS = (32'd1 << OP_DIV) | (32'd1 << OP_DIVU);
  localparam logic [31:0] SIGNED_OPS    = (32'd1 << OP_MULT) | (32'd1 << OP_MUL)  |
                                          (32'd1 << OP_MADD) | (32'd1 << OP_MSUB) |
                                          (32'd1 << OP_DIV);
  localparam logic [31:0] ACC_OPS       = (32'd1 << OP_MADD) | (32'd1 << OP_MADDU) |
                                          (32'd1 << OP_MSUB) | (32'd1 << OP_MSUBU);
  localparam logic [31:0] SUB_OPS       = (32'd1 << OP_MSUB) | (32'd1 << OP_MSUBU);

  function automatic logic op_in(input logic [31:0] op_set, input oper_t op);
    return op_set[op];
  endfunction

endpackage

// File: rtl/exec_muldiv_div_iter.sv
// Unsigned restoring divider core: retires DIV_BITS quotient bits per enabled cycle.
module div_iter #(
  parameter int DATA_WIDTH = 32,
  parameter int DIV_BITS   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_dividend,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  output logic                  o_last,
  output logic [DATA_WIDTH-1:0] o_quot,
  output logic [DATA_WIDTH-1:0] o_rem
);

  localparam int ITERS = (DATA_WIDTH + DIV_BITS - 1) / DIV_BITS;
  localparam int QW    = ITERS * DIV_BITS;
  localparam int CW    = $clog2(ITERS + 1);

  logic [QW-1:0]         r_quo;
  logic [DATA_WIDTH-1:0] r_rem;
  logic [DATA_WIDTH-1:0] r_div;
  logic [CW-1:0]         r_cnt;

  logic [DATA_WIDTH-1:0] w_rem [0:DIV_BITS];
  logic [QW-1:0]         w_quo [0:DIV_BITS];

  assign w_rem[0] = r_rem;
  assign w_quo[0] = r_quo;

  // Dividend bits shift out of the top of r_quo while quotient bits shift in at the bottom.
  genvar gi;
  generate
    for (gi = 0; gi < DIV_BITS; gi++) begin : g_step
      logic [DATA_WIDTH:0] w_trial;
      logic                w_ge;
      assign w_trial        = {w_rem[gi], w_quo[gi][QW-1]};
      assign w_ge           = (w_trial >= {1'b0, r_div});
      assign w_rem[gi+1]    = w_ge ? DATA_WIDTH'(w_trial - {1'b0, r_div}) : w_trial[DATA_WIDTH-1:0];
      assign w_quo[gi+1]    = {w_quo[gi][QW-2:0], w_ge};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_quo <= '0;
      r_rem <= '0;
      r_div <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_quo <= QW'(i_dividend);
      r_rem <= '0;
      r_div <= i_divisor;
      r_cnt <= CW'(ITERS - 1);
    end else if (i_en) begin
      r_quo <= w_quo[DIV_BITS];
      r_rem <= w_rem[DIV_BITS];
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_last = (r_cnt == '0);
  assign o_quot = r_quo[DATA_WIDTH-1:0];
  assign o_rem  = r_rem;

endmodule

// File: rtl/exec_muldiv.sv
// HI/LO multiply-divide execution unit: pipelined multiplier, iterative divider,
// accumulate ops, and commit of the architected {HI,LO} pair.
module exec_muldiv
  import exec_muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DIV_BITS   = 1,
  parameter int MUL_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  oper_t                   req_op,
  input  logic [DATA_WIDTH-1:0]   req_reg0,
  input  logic [DATA_WIDTH-1:0]   req_reg1,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_mul,
  output logic [2*DATA_WIDTH-1:0] hilo_rddata,
  output logic                    busy
);

  localparam int W  = DATA_WIDTH;
  localparam int W2 = 2 * DATA_WIDTH;

  muldiv_state_t r_state;
  oper_t         r_op;
  logic [W-1:0]  r_a, r_b, r_hi, r_lo;
  logic [W2-1:0] r_acc, r_res;
  logic [2:0]    r_mcnt;
  logic          r_dz, r_q_neg, r_r_neg;

  logic          w_op_mul, w_op_div, w_op_mt, w_accept, w_req_signed;
  logic          w_neg_a, w_neg_b, w_div_start, w_div_last, w_mul_signed;
  logic [W-1:0]  w_abs_a, w_abs_b, w_quot, w_rem, w_q_fix, w_r_fix;
  logic [W2-1:0] w_ma, w_mb, w_prod, w_mul_res;
  logic [W2-1:0] w_stage [0:MUL_STAGES-1];

  assign w_op_mul     = op_in(MUL_CLASS_OPS, req_op);
  assign w_op_div     = op_in(DIV_CLASS_OPS, req_op);
  assign w_op_mt      = (req_op == OP_MTHI) || (req_op == OP_MTLO);
  assign w_accept     = req_valid && (r_state == MD_IDLE) && !flush &&
                        (w_op_mul || w_op_div || w_op_mt);
  assign w_req_signed = op_in(SIGNED_OPS, req_op);
  assign w_neg_a      = w_req_signed & req_reg0[W-1];
  assign w_neg_b      = w_req_signed & req_reg1[W-1];
  assign w_abs_a      = w_neg_a ? -req_reg0 : req_reg0;
  assign w_abs_b      = w_neg_b ? -req_reg1 : req_reg1;
  assign w_div_start  = w_accept && w_op_div && (req_reg1 != '0);

  // Full-width product of extended operands; low 2W bits equal the signed/unsigned product.
  assign w_mul_signed = op_in(SIGNED_OPS, r_op);
  assign w_ma         = {{W{w_mul_signed & r_a[W-1]}}, r_a};
  assign w_mb         = {{W{w_mul_signed & r_b[W-1]}}, r_b};
  assign w_prod       = w_ma * w_mb;
  assign w_stage[0]   = w_prod;

  genvar gi;
  generate
    for (gi = 1; gi < MUL_STAGES; gi++) begin : g_mul_pipe
      logic [W2-1:0] r_pipe;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_pipe <= '0;
        else      r_pipe <= w_stage[gi-1];
      end
      assign w_stage[gi] = r_pipe;
    end
  endgenerate

  assign w_mul_res = op_in(SUB_OPS, r_op) ? (r_acc - w_stage[MUL_STAGES-1])
                                          : (r_acc + w_stage[MUL_STAGES-1]);

  div_iter #(
    .DATA_WIDTH (DATA_WIDTH),
    .DIV_BITS   (DIV_BITS)
  ) u_div_iter (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_en       (r_state == MD_DIV),
    .i_dividend (w_abs_a),
    .i_divisor  (w_abs_b),
    .o_last     (w_div_last),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );

  assign w_q_fix = r_q_neg ? -w_quot : w_quot;
  assign w_r_fix = r_r_neg ? -w_rem  : w_rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= MD_IDLE;
      r_op    <= OP_NOP;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_acc   <= '0;
      r_res   <= '0;
      r_mcnt  <= '0;
      r_dz    <= 1'b0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
    end else if (flush) begin
      r_state <= MD_IDLE;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (w_accept) begin
            r_op    <= req_op;
            r_a     <= req_reg0;
            r_b     <= req_reg1;
            r_acc   <= op_in(ACC_OPS, req_op) ? {r_hi, r_lo} : '0;
            r_mcnt  <= '0;
            r_dz    <= (req_reg1 == '0);
            r_q_neg <= w_neg_a ^ w_neg_b;
            r_r_neg <= w_neg_a;
            if (w_op_mul)                r_state <= MD_MUL;
            else if (!w_op_div)          r_state <= MD_DONE;
            else if (req_reg1 == '0)     r_state <= MD_FIX;
            else                         r_state <= MD_DIV;
          end
        end
        MD_MUL: begin
          if (r_mcnt == 3'(MUL_STAGES - 1)) begin
            r_res   <= w_mul_res;
            r_state <= MD_DONE;
          end else begin
            r_mcnt <= r_mcnt + 3'd1;
          end
        end
        MD_DIV: begin
          if (w_div_last) r_state <= MD_FIX;
        end
        MD_FIX: begin
          r_res   <= r_dz ? {r_a, {W{1'b1}}} : {w_r_fix, w_q_fix};
          r_state <= MD_DONE;
        end
        MD_DONE: begin
          case (r_op)
            OP_MTHI: r_hi <= r_a;
            OP_MTLO: r_lo <= r_a;
            OP_MUL:  ;
            default: {r_hi, r_lo} <= r_res;
          endcase
          r_state <= MD_IDLE;
        end
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  assign req_ready   = (r_state == MD_IDLE);
  assign busy        = (r_state != MD_IDLE);
  assign resp_valid  = (r_state == MD_DONE) && !flush;
  assign resp_mul    = (resp_valid && (r_op == OP_MUL)) ? r_res[W-1:0] : '0;
  assign hilo_rddata = {r_hi, r_lo};

endmodule

// File: tb/tb_exec_muldiv.sv
// Directed self-checking bench for exec_muldiv with default parameters.
module tb_exec_muldiv;
  import exec_muldiv_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  oper_t       req_op;
  logic [31:0] req_reg0;
  logic [31:0] req_reg1;
  logic        resp_valid;
  logic [31:0] resp_mul;
  logic [63:0] hilo_rddata;
  logic        busy;

  int          total;
  int          bad;
  logic [31:0] last_mul;

  exec_muldiv #(
    .DATA_WIDTH (32),
    .DIV_BITS   (1),
    .MUL_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_reg0    (req_reg0),
    .req_reg1    (req_reg1),
    .resp_valid  (resp_valid),
    .resp_mul    (resp_mul),
    .hilo_rddata (hilo_rddata),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, scramble the inputs after accept, measure latency and check {HI,LO}.
  task automatic run_op(input string tag, input oper_t op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [63:0] exp_hilo);
    int lat;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_reg0  = a;
    req_reg1  = b;
    chk({tag, " ready"}, 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = OP_NOP;
    req_reg0  = ~a;
    req_reg1  = ~b;
    lat       = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat      = n;
        last_mul = resp_mul;
        break;
      end
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    @(negedge clk);
    chk({tag, " hilo"}, hilo_rddata, exp_hilo);
    chk({tag, " idle"}, {31'd0, resp_valid, resp_mul}, 64'd0);
    $display("txn %s op=%0d a=%h b=%h lat=%0d hilo=%h", tag, op, a, b, lat, hilo_rddata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total     = 0;
    bad       = 0;
    last_mul  = '0;
    rst       = 1'b0;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_op    = OP_NOP;
    req_reg0  = '0;
    req_reg1  = '0;

    #1;
    chk("reset ready", 64'(req_ready), 64'd1);
    chk("reset outs", {30'd0, resp_valid, busy, resp_mul}, 64'd0);
    chk("reset hilo", hilo_rddata, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op("mult", OP_MULT, 32'hFFFFFFFE, 32'd3, 3, 64'hFFFFFFFF_FFFFFFFA);
    run_op("mul", OP_MUL, 32'd7, 32'hFFFFFFFB, 3, 64'hFFFFFFFF_FFFFFFFA);
    chk("mul resp_mul", 64'(last_mul), 64'h0000_0000_FFFF_FFDD);
    run_op("multu", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 3, 64'hFFFFFFFE_00000001);
    run_op("div -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, 34, 64'hFFFFFFFF_FFFFFFFD);
    run_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFFFFFE, 34, 64'h00000001_FFFFFFFD);
    run_op("div ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 34, 64'h00000000_80000000);
    run_op("divu", OP_DIVU, 32'hFFFFFFFF, 32'd10, 34, 64'h00000005_19999999);
    run_op("divu by0", OP_DIVU, 32'h00001234, 32'd0, 2, 64'h00001234_FFFFFFFF);
    run_op("div by0", OP_DIV, 32'hFFFFFFF9, 32'd0, 2, 64'hFFFFFFF9_FFFFFFFF);
    run_op("mtlo", OP_MTLO, 32'd0, 32'd0, 1, 64'hFFFFFFF9_00000000);
    run_op("mthi", OP_MTHI, 32'd5, 32'd0, 1, 64'h00000005_00000000);
    run_op("maddu", OP_MADDU, 32'd2, 32'd3, 3, 64'h00000005_00000006);
    run_op("msubu", OP_MSUBU, 32'd1, 32'd7, 3, 64'h00000004_FFFFFFFF);
    run_op("madd", OP_MADD, 32'hFFFFFFFF, 32'd1, 3, 64'h00000004_FFFFFFFE);
    run_op("msub", OP_MSUB, 32'hFFFFFFFE, 32'd3, 3, 64'h00000005_00000004);

    // Unsupported op is dropped
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_ADD;
    req_reg0  = 32'd1;
    req_reg1  = 32'd2;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = OP_NOP;
    @(negedge clk);
    chk("badop busy", 64'(busy), 64'd0);
    chk("badop hilo", hilo_rddata, 64'h00000005_00000004);
    $display("txn badop busy=%0d hilo=%h", busy, hilo_rddata);

    // Flush at divide iteration 10
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_DIV;
    req_reg0  = 32'd100;
    req_reg1  = 32'd3;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = OP_NOP;
    repeat (10) @(negedge clk);
    chk("flushdiv busy before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flushdiv busy after", 64'(busy), 64'd0);
    chk("flushdiv hilo", hilo_rddata, 64'h00000005_00000004);
    $display("txn flushdiv busy=%0d hilo=%h", busy, hilo_rddata);
    run_op("post-flush mtlo", OP_MTLO, 32'd9, 32'd0, 1, 64'h00000005_00000009);

    // Flush during the DONE cycle suppresses response and commit
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_MTHI;
    req_reg0  = 32'd77;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = OP_NOP;
    @(negedge clk);
    chk("flushdone busy", 64'(busy), 64'd1);
    flush = 1'b1;
    #1;
    chk("flushdone resp_valid", 64'(resp_valid), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flushdone hilo", hilo_rddata, 64'h00000005_00000009);
    chk("flushdone idle", 64'(busy), 64'd0);
    $display("txn flushdone hilo=%h", hilo_rddata);

    // Asynchronous reset in the middle of a multiply
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_MULT;
    req_reg0  = 32'd3;
    req_reg1  = 32'd4;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = OP_NOP;
    @(negedge clk);
    chk("rstmul busy", 64'(busy), 64'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("rstmul ready", 64'(req_ready), 64'd1);
    chk("rstmul outs", {30'd0, resp_valid, busy, resp_mul}, 64'd0);
    chk("rstmul hilo", hilo_rddata, 64'd0);
    $display("txn rstmul busy=%0d hilo=%h", busy, hilo_rddata);

    // Request presented on the first edge after reset release
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 1'b1;
    req_op    = OP_MTLO;
    req_reg0  = 32'd9;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = OP_NOP;
    @(negedge clk);
    chk("postrst resp_valid", 64'(resp_valid), 64'd1);
    @(negedge clk);
    chk("postrst hilo", hilo_rddata, 64'h00000000_00000009);
    $display("txn postrst mtlo hilo=%h", hilo_rddata);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
